// File: rtl/prog_loader.sv
// Program loader: accepts a length-prefixed byte stream and writes each
// 16-bit word into the program SRAM with a setup / WE-pulse / hold sequence.
module prog_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic [17:0] Ram2Addr,
  inout  wire  [15:0] Ram2Data,
  output logic        Ram2OE,
  output logic        Ram2WE,
  output logic        Ram2EN,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_written
);

  typedef enum logic [3:0] {
    IDLE, LEN_LO, LEN_HI, DAT_LO, DAT_HI, WR_SETUP, WR_PULSE, WR_HOLD, DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] len_q,   len_d;
  logic [7:0]  lo_q,    lo_d;
  logic [15:0] word_q,  word_d;
  logic [17:0] addr_q,  addr_d;
  logic [15:0] count_q, count_d;
  logic        drive;

  // Outputs are pure decodes of the state register, so none of them glitch on byte_valid.
  assign byte_ready    = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                         (state_q == DAT_LO) || (state_q == DAT_HI);
  assign drive         = (state_q == WR_SETUP) || (state_q == WR_PULSE) || (state_q == WR_HOLD);
  assign busy          = (state_q != IDLE) && (state_q != DONE);
  assign done          = (state_q == DONE);
  assign Ram2WE        = (state_q != WR_PULSE);
  assign Ram2OE        = busy;
  assign Ram2EN        = 1'b0;
  assign Ram2Addr      = addr_q;
  assign Ram2Data      = drive ? word_q : 16'bz;
  assign words_written = count_q;

  always_comb begin
    // NOTE: every _d is given its hold value first so no branch can leave a latch behind.
    state_d = state_q;
    len_d   = len_q;
    lo_d    = lo_q;
    word_d  = word_q;
    addr_d  = addr_q;
    count_d = count_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LEN_LO;
          addr_d  = '0;
          count_d = '0;
        end
      end
      LEN_LO: begin
        if (byte_valid) begin
          len_d[7:0] = byte_data;
          state_d    = LEN_HI;
        end
      end
      LEN_HI: begin
        if (byte_valid) begin
          len_d[15:8] = byte_data;
          state_d     = ({byte_data, len_q[7:0]} == 16'd0) ? DONE : DAT_LO;
        end
      end
      DAT_LO: begin
        if (byte_valid) begin
          lo_d    = byte_data;
          state_d = DAT_HI;
        end
      end
      DAT_HI: begin
        if (byte_valid) begin
          word_d  = {byte_data, lo_q};
          state_d = WR_SETUP;
        end
      end
      WR_SETUP: state_d = WR_PULSE;
      WR_PULSE: state_d = WR_HOLD;
      WR_HOLD: begin
        count_d = count_q + 16'd1;
        addr_d  = addr_q + 18'd1;
        state_d = (count_q + 16'd1 == len_q) ? DONE : DAT_LO;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; rst is sampled on the clock like any input.
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      lo_q    <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      lo_q    <= lo_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

endmodule
